pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator, successor to the single-channel PWM block. It drives NCH independent PWM outputs from one clock. Each channel has its own period and duty cycle, and optionally runs a burst pattern. Configuration is double-buffered and applied only at period boundaries so outputs never glitch. It sits between the register/config logic and the output pins, for motor, LED and tone drive.

---
 rtl/pwm_pkg.sv | 28 ++
 rtl/pwm_channel.sv | 165 ++++++++++++++++
 rtl/pwm_multi.sv | 42 ++++
 tb/tb_pwm_multi.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
// Holds the channel state encoding, duty limits and the high-count computation.
package pwm_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd100;

  // Widest period the high-count helper accepts, and its product width (+7 bits covers x100).
  localparam int HC_IN_W   = 32;
  localparam int HC_PROD_W = HC_IN_W + 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP
  } pwm_state_e;

  // High cycles per period: period * min(duty,100) / 100, truncated.
  function automatic logic [HC_IN_W-1:0] calc_high_cnt(input logic [HC_IN_W-1:0] period,
                                                       input logic [DUTY_W-1:0]  duty);
    logic [DUTY_W-1:0]    duty_c;
    logic [HC_PROD_W-1:0] prod;
    duty_c = (duty > DUTY_MAX) ? DUTY_MAX : duty;
    prod   = HC_PROD_W'(period) * HC_PROD_W'(duty_c);
    return HC_IN_W'(prod / HC_PROD_W'(DUTY_MAX));
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered config, RUN/GAP burst FSM, period counter
// and registered PWM / period-end outputs.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CW = 16,
  parameter int BW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load,
  input  logic [CW-1:0]     period_in,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic [BW-1:0]     blen_in,
  input  logic [BW-1:0]     bgap_in,
  output logic              pwm,
  output logic              period_end,
  output logic              active
);

  pwm_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [BW-1:0] gap_cnt_q, gap_cnt_d;
  logic [CW-1:0] sh_period_q, sh_period_d, sh_high_q, sh_high_d;
  logic [BW-1:0] sh_blen_q, sh_blen_d, sh_bgap_q, sh_bgap_d;
  logic [CW-1:0] act_period_q, act_period_d, act_high_q, act_high_d;
  logic [BW-1:0] act_blen_q, act_blen_d, act_bgap_q, act_bgap_d;
  logic          pending_q, pending_d;
  logic          pwm_q, pwm_d;
  logic          pend_q, pend_d;

  logic running, per_zero, boundary, apply;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    burst_cnt_d  = burst_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    sh_period_d  = sh_period_q;
    sh_high_d    = sh_high_q;
    sh_blen_d    = sh_blen_q;
    sh_bgap_d    = sh_bgap_q;
    act_period_d = act_period_q;
    act_high_d   = act_high_q;
    act_blen_d   = act_blen_q;
    act_bgap_d   = act_bgap_q;
    pending_d    = pending_q;

    running  = (state_q != ST_IDLE);
    per_zero = (act_period_q == '0);
    boundary = !per_zero && (cnt_q == act_period_q - CW'(1));
    // A zero period has no boundary to wait for, so any cycle may take new config.
    apply    = pending_q && (!running || per_zero || boundary);

    // A Load coinciding with apply keeps pending set: the old shadow goes live now,
    // the freshly captured one at the following boundary.
    if (load) begin
      sh_period_d = period_in;
      sh_high_d   = CW'(calc_high_cnt(HC_IN_W'(period_in), duty_in));
      sh_blen_d   = blen_in;
      sh_bgap_d   = bgap_in;
      pending_d   = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end

    if (apply) begin
      act_period_d = sh_period_q;
      act_high_d   = sh_high_q;
      act_blen_d   = sh_blen_q;
      act_bgap_d   = sh_bgap_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d     = ST_RUN;
          burst_cnt_d = '0;
          gap_cnt_d   = '0;
        end
      end
      ST_RUN, ST_GAP: begin
        if (!per_zero) cnt_d = boundary ? '0 : cnt_q + CW'(1);
        if (state_q == ST_RUN && boundary && act_blen_q != '0) begin
          if (({1'b0, burst_cnt_q} + (BW+1)'(1)) >= {1'b0, act_blen_q}) begin
            burst_cnt_d = '0;
            if (act_bgap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end
        if (state_q == ST_GAP && boundary) begin
          if (({1'b0, gap_cnt_q} + (BW+1)'(1)) >= {1'b0, act_bgap_q}) begin
            state_d     = ST_RUN;
            burst_cnt_d = '0;
            gap_cnt_d   = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable wins immediately, without waiting for the period to finish.
    if (!enable) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      burst_cnt_d = '0;
      gap_cnt_d   = '0;
    end

    pwm_d  = (state_q == ST_RUN) && (cnt_q < act_high_q);
    pend_d = running && boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      burst_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      sh_period_q  <= '0;
      sh_high_q    <= '0;
      sh_blen_q    <= '0;
      sh_bgap_q    <= '0;
      act_period_q <= '0;
      act_high_q   <= '0;
      act_blen_q   <= '0;
      act_bgap_q   <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      sh_period_q  <= sh_period_d;
      sh_high_q    <= sh_high_d;
      sh_blen_q    <= sh_blen_d;
      sh_bgap_q    <= sh_bgap_d;
      act_period_q <= act_period_d;
      act_high_q   <= act_high_d;
      act_blen_q   <= act_blen_d;
      act_bgap_q   <= act_bgap_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      pend_q       <= pend_d;
    end
  end

  assign pwm        = pwm_q;
  assign period_end = pend_q;
  assign active     = (state_q != ST_IDLE);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: NCH independent pwm_channel instances fed from
// flattened per-channel configuration buses.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int BW  = 8
) (
  input  logic                  SysClk,
  input  logic                  Reset,
  input  logic [NCH-1:0]        Enable,
  input  logic [NCH-1:0]        Load,
  input  logic [NCH*CW-1:0]     Period,
  input  logic [NCH*DUTY_W-1:0] DutyCycle,
  input  logic [NCH*BW-1:0]     BurstLen,
  input  logic [NCH*BW-1:0]     BurstGap,
  output logic [NCH-1:0]        PWM,
  output logic [NCH-1:0]        PeriodEnd,
  output logic [NCH-1:0]        Active
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_channel #(
      .CW(CW),
      .BW(BW)
    ) u_ch (
      .clk       (SysClk),
      .rst_n     (Reset),
      .enable    (Enable[i]),
      .load      (Load[i]),
      .period_in (Period[i*CW +: CW]),
      .duty_in   (DutyCycle[i*DUTY_W +: DUTY_W]),
      .blen_in   (BurstLen[i*BW +: BW]),
      .bgap_in   (BurstGap[i*BW +: BW]),
      .pwm       (PWM[i]),
      .period_end(PeriodEnd[i]),
      .active    (Active[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: cycle model + scoreboard queue on every
// channel, table-driven steady-state vectors, and hand-written corner sequences.
module tb_pwm_multi;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int BW  = 8;

  logic              SysClk;
  logic              Reset;
  logic [NCH-1:0]    Enable;
  logic [NCH-1:0]    Load;
  logic [NCH*CW-1:0] Period;
  logic [NCH*8-1:0]  DutyCycle;
  logic [NCH*BW-1:0] BurstLen;
  logic [NCH*BW-1:0] BurstGap;
  logic [NCH-1:0]    PWM;
  logic [NCH-1:0]    PeriodEnd;
  logic [NCH-1:0]    Active;

  pwm_multi #(.NCH(NCH), .CW(CW), .BW(BW)) dut (
    .SysClk   (SysClk),
    .Reset    (Reset),
    .Enable   (Enable),
    .Load     (Load),
    .Period   (Period),
    .DutyCycle(DutyCycle),
    .BurstLen (BurstLen),
    .BurstGap (BurstGap),
    .PWM      (PWM),
    .PeriodEnd(PeriodEnd),
    .Active   (Active)
  );

  initial begin
    SysClk = 1'b0;
    forever #5 SysClk = ~SysClk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int st;                  // 0 idle, 1 run, 2 gap
    int cnt, bc, gc;
    int s_per, s_hi, s_bl, s_bg;
    int a_per, a_hi, a_bl, a_bg;
    bit pend;
    bit pwm, pe;
  } mch_t;

  mch_t           m [NCH];
  mch_t           o, n;
  bit             last, running, apply;
  int             d;
  logic [NCH-1:0] e_pwm, e_pe, e_act;
  logic [3*NCH-1:0] exp_q[$];
  logic [3*NCH-1:0] e_pop;

  always @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NCH; i++) m[i] = '{default: 0};
      exp_q.delete();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        o = m[i];
        n = o;
        last    = (o.a_per != 0) && (o.cnt == o.a_per - 1);
        running = (o.st != 0);
        apply   = o.pend && (!running || o.a_per == 0 || last);
        if (Load[i]) begin
          n.s_per = int'(Period[i*CW +: CW]);
          d = int'(DutyCycle[i*8 +: 8]);
          if (d > 100) d = 100;
          n.s_hi  = (n.s_per * d) / 100;
          n.s_bl  = int'(BurstLen[i*BW +: BW]);
          n.s_bg  = int'(BurstGap[i*BW +: BW]);
          n.pend  = 1'b1;
        end else if (apply) begin
          n.pend = 1'b0;
        end
        if (apply) begin
          n.a_per = o.s_per; n.a_hi = o.s_hi; n.a_bl = o.s_bl; n.a_bg = o.s_bg;
        end
        n.pwm = (o.st == 1) && (o.cnt < o.a_hi);
        n.pe  = running && last;
        if (!Enable[i]) begin
          n.st = 0; n.cnt = 0; n.bc = 0; n.gc = 0;
        end else if (o.st == 0) begin
          n.st = 1; n.cnt = 0; n.bc = 0; n.gc = 0;
        end else begin
          if (o.a_per != 0) n.cnt = last ? 0 : o.cnt + 1;
          if (o.st == 1 && last && o.a_bl != 0) begin
            if (o.bc >= o.a_bl - 1) begin
              n.bc = 0;
              if (o.a_bg != 0) begin n.st = 2; n.gc = 0; end
            end else n.bc = o.bc + 1;
          end
          if (o.st == 2 && last) begin
            if (o.gc >= o.a_bg - 1) begin n.st = 1; n.bc = 0; n.gc = 0; end
            else n.gc = o.gc + 1;
          end
        end
        m[i] = n;
        e_pwm[i] = n.pwm;
        e_pe[i]  = n.pe;
        e_act[i] = (n.st != 0);
      end
      exp_q.push_back({e_pwm, e_pe, e_act});
    end
  end

  always @(negedge SysClk) begin
    if (!Reset) begin
      check("reset_outputs", 32'({PWM, PeriodEnd, Active}), 0);
    end else if (exp_q.size() > 0) begin
      e_pop = exp_q.pop_front();
      check("scoreboard", 32'({PWM, PeriodEnd, Active}), 32'(e_pop));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cfg(input int ch, input int per, input int duty, input int bl, input int bg);
    Period[ch*CW +: CW]   = CW'(per);
    DutyCycle[ch*8 +: 8]  = 8'(duty);
    BurstLen[ch*BW +: BW] = BW'(bl);
    BurstGap[ch*BW +: BW] = BW'(bg);
  endtask

  task automatic pulse_load(input logic [NCH-1:0] mask);
    Load = mask;
    @(negedge SysClk);
    Load = '0;
  endtask

  task automatic do_reset();
    @(posedge SysClk);
    #2;
    Reset  = 1'b0;
    Enable = '0;
    Load   = '0;
    repeat (2) @(negedge SysClk);
    Reset = 1'b1;
  endtask

  task automatic wait_pe(input int ch, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge SysClk);
      if (PeriodEnd[ch]) begin
        seen = 1'b1;
        break;
      end
    end
    check("wait_period_end", 32'(seen), 1);
  endtask

  typedef struct {
    int per;
    int duty;
    int win;
    int exp_highs;
    int exp_pes;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int highs, pes, acts, run, max_run;
    int h[3];
    int pe_at[3];
    int ch_hi[NCH];
    int ch_pe[NCH];
    int exp_ch_hi[NCH];
    int exp_ch_pe[NCH];
    bit found;

    Reset = 1'b0; Enable = '0; Load = '0;
    Period = '0; DutyCycle = '0; BurstLen = '0; BurstGap = '0;

    // window = 5 periods; highs = 5*HighCnt
    vecs[0] = '{per: 10, duty: 30,  win: 50, exp_highs: 15, exp_pes: 5};
    vecs[1] = '{per: 10, duty: 0,   win: 50, exp_highs: 0,  exp_pes: 5};
    vecs[2] = '{per: 10, duty: 100, win: 50, exp_highs: 50, exp_pes: 5};
    vecs[3] = '{per: 10, duty: 150, win: 50, exp_highs: 50, exp_pes: 5};
    vecs[4] = '{per: 7,  duty: 33,  win: 35, exp_highs: 10, exp_pes: 5};
    vecs[5] = '{per: 0,  duty: 50,  win: 50, exp_highs: 0,  exp_pes: 0};
    vecs[6] = '{per: 13, duty: 50,  win: 65, exp_highs: 30, exp_pes: 5};
    vecs[7] = '{per: 1,  duty: 100, win: 5,  exp_highs: 5,  exp_pes: 5};

    repeat (2) @(negedge SysClk);
    check("reset_state", 32'({PWM, PeriodEnd, Active}), 0);
    Reset = 1'b1;

    // Never-loaded channel: RUN with Period=0, output low, no PeriodEnd.
    Enable = 4'b0001;
    @(negedge SysClk);
    @(negedge SysClk);
    highs = 0; pes = 0;
    repeat (30) begin
      @(negedge SysClk);
      highs += int'(PWM[0]); pes += int'(PeriodEnd[0]);
    end
    check("unloaded_highs", highs, 0);
    check("unloaded_pes", pes, 0);
    check("unloaded_active", 32'(Active[0]), 1);

    // Table-driven steady-state vectors on channel 0.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      set_cfg(0, vecs[v].per, vecs[v].duty, 0, 0);
      pulse_load(4'b0001);
      Enable = 4'b0001;
      repeat (40) @(negedge SysClk);
      highs = 0; pes = 0; acts = 0;
      repeat (vecs[v].win) begin
        @(negedge SysClk);
        highs += int'(PWM[0]); pes += int'(PeriodEnd[0]); acts += int'(Active[0]);
      end
      check($sformatf("vec%0d_highs", v), highs, vecs[v].exp_highs);
      check($sformatf("vec%0d_pes", v), pes, vecs[v].exp_pes);
      check($sformatf("vec%0d_active", v), acts, vecs[v].win);
    end

    // Glitch-free update: duty 50 -> 80 loaded mid-period, then 20 loaded on the boundary.
    do_reset();
    set_cfg(0, 10, 50, 0, 0);
    pulse_load(4'b0001);
    Enable = 4'b0001;
    wait_pe(0, 40);
    h[0] = 0; h[1] = 0; h[2] = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge SysClk);
      h[(j-1)/10] += int'(PWM[0]);
      if (j % 10 == 0) pe_at[j/10 - 1] = int'(PeriodEnd[0]);
      if (j == 4)  begin set_cfg(0, 10, 80, 0, 0); Load = 4'b0001; end
      if (j == 5)  Load = '0;
      if (j == 9)  begin set_cfg(0, 10, 20, 0, 0); Load = 4'b0001; end
      if (j == 10) Load = '0;
    end
    check("glitch_p1_highs", h[0], 5);
    check("glitch_p2_highs", h[1], 8);
    check("glitch_p3_highs", h[2], 2);
    check("glitch_pe1", pe_at[0], 1);
    check("glitch_pe2", pe_at[1], 1);
    check("glitch_pe3", pe_at[2], 1);

    // Burst: P8 D50 BL3 BG2 -> 3x(4H4L) then 16 low.
    do_reset();
    set_cfg(0, 8, 50, 3, 2);
    pulse_load(4'b0001);
    Enable = 4'b0001;
    repeat (20) @(negedge SysClk);
    highs = 0; acts = 0; run = 0; max_run = 0;
    repeat (80) begin
      @(negedge SysClk);
      highs += int'(PWM[0]); acts += int'(Active[0]);
      run = PWM[0] ? 0 : run + 1;
      if (run > max_run) max_run = run;
    end
    check("burst_highs", highs, 24);
    check("burst_max_low_run", max_run, 20);
    check("burst_active", acts, 80);

    // Async reset while in GAP.
    run = 0; found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge SysClk);
      run = PWM[0] ? 0 : run + 1;
      if (run >= 10) begin found = 1'b1; break; end
    end
    check("found_gap", 32'(found), 1);
    @(posedge SysClk);
    #1;
    check("gap_pre_reset_active", 32'(Active[0]), 1);
    #1;
    Reset = 1'b0;
    #1;
    check("gap_reset_pwm", 32'(PWM[0]), 0);
    check("gap_reset_active", 32'(Active[0]), 0);
    check("gap_reset_pe", 32'(PeriodEnd[0]), 0);
    Enable = '0;
    @(negedge SysClk);
    Reset = 1'b1;
    repeat (5) @(negedge SysClk);
    check("post_reset_idle", 32'({PWM[0], Active[0]}), 0);

    // Async reset during RUN high phase.
    set_cfg(0, 8, 50, 3, 2);
    pulse_load(4'b0001);
    Enable = 4'b0001;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge SysClk);
      if (PWM[0]) begin found = 1'b1; break; end
    end
    check("found_high", 32'(found), 1);
    @(posedge SysClk);
    #1;
    check("run_pre_reset_pwm", 32'(PWM[0]), 1);
    #1;
    Reset = 1'b0;
    #1;
    check("run_reset_pwm", 32'(PWM[0]), 0);
    check("run_reset_active", 32'(Active[0]), 0);
    check("run_reset_pe", 32'(PeriodEnd[0]), 0);
    Enable = '0;
    @(negedge SysClk);
    Reset = 1'b1;
    repeat (3) @(negedge SysClk);

    // Multi-channel: simultaneous Load, periods 5/6/7/8, one LCM window of 840 cycles.
    do_reset();
    set_cfg(0, 5, 40, 0, 0);
    set_cfg(1, 6, 50, 0, 0);
    set_cfg(2, 7, 33, 0, 0);
    set_cfg(3, 8, 75, 0, 0);
    pulse_load(4'b1111);
    Enable = 4'b1111;
    repeat (20) @(negedge SysClk);
    for (int c = 0; c < NCH; c++) begin ch_hi[c] = 0; ch_pe[c] = 0; end
    repeat (840) begin
      @(negedge SysClk);
      for (int c = 0; c < NCH; c++) begin
        ch_hi[c] += int'(PWM[c]);
        ch_pe[c] += int'(PeriodEnd[c]);
      end
    end
    exp_ch_hi = '{336, 420, 240, 630};
    exp_ch_pe = '{168, 140, 120, 105};
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("multi_ch%0d_highs", c), ch_hi[c], exp_ch_hi[c]);
      check($sformatf("multi_ch%0d_pes", c), ch_pe[c], exp_ch_pe[c]);
    end

    // Reload two channels together, bounce another's Enable; scoreboard tracks all.
    set_cfg(1, 6, 50, 2, 1);
    set_cfg(3, 4, 25, 0, 0);
    pulse_load(4'b1010);
    repeat (50) @(negedge SysClk);
    Enable[2] = 1'b0;
    repeat (3) @(negedge SysClk);
    check("ch2_disabled", 32'(Active[2]), 0);
    Enable[2] = 1'b1;
    repeat (200) @(negedge SysClk);
    Enable = '0;
    repeat (3) @(negedge SysClk);
    check("all_idle", 32'(Active), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
